// File: rtl/nrr_victim_gen.sv
// Buffers NRR aggressor requests in a small FIFO and issues their victim rows over valid/ready.
// Define NRR_BLAST_RADIUS2_EN to add the +/-2 victims after the +/-1 pair.
module nrr_victim_gen #(
  parameter int ADDR_SIZE       = 18,
  parameter int FIFO_DEPTH      = 4,
  parameter int FIFO_DEPTH_BITS = 2,
  parameter int DROP_CNT_SIZE   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     nrr_cmd,
  input  logic [ADDR_SIZE-1:0]     nrr_addr,
  output logic                     vrr_valid,
  input  logic                     vrr_ready,
  output logic [ADDR_SIZE-1:0]     vrr_addr,
  output logic                     busy,
  output logic                     fifo_full,
  output logic [DROP_CNT_SIZE-1:0] drop_cnt
);

`ifdef NRR_BLAST_RADIUS2_EN
  localparam int NUM_OFF = 4;
  localparam int IDX_W   = 2;
`else
  localparam int NUM_OFF = 2;
  localparam int IDX_W   = 1;
`endif

  localparam logic [FIFO_DEPTH_BITS:0]   FULL_CNT = (FIFO_DEPTH_BITS+1)'(FIFO_DEPTH);
  localparam logic [FIFO_DEPTH_BITS-1:0] LAST_PTR = FIFO_DEPTH_BITS'(FIFO_DEPTH-1);

  typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  // Victim computed one bit wider; a set MSB means the row fell off either end of the bank.
  function automatic logic [ADDR_SIZE:0] victim_sum(input logic [ADDR_SIZE-1:0] agg,
                                                    input logic [1:0]           idx);
    logic [ADDR_SIZE:0] ext;
    ext = {1'b0, agg};
    case (idx)
      2'd0:    victim_sum = ext - (ADDR_SIZE+1)'(1);
      2'd1:    victim_sum = ext + (ADDR_SIZE+1)'(1);
`ifdef NRR_BLAST_RADIUS2_EN
      2'd2:    victim_sum = ext - (ADDR_SIZE+1)'(2);
      2'd3:    victim_sum = ext + (ADDR_SIZE+1)'(2);
`endif
      default: victim_sum = ext;
    endcase
  endfunction

  // Returns {found, idx} for the lowest legal offset index >= start.
  function automatic logic [IDX_W:0] find_legal(input logic [ADDR_SIZE-1:0] agg,
                                                input int                   start);
    logic [ADDR_SIZE:0] sum;
    find_legal = '0;
    for (int i = NUM_OFF - 1; i >= 0; i--) begin
      sum = victim_sum(agg, 2'(i));
      if ((i >= start) && !sum[ADDR_SIZE]) begin
        find_legal = {1'b1, IDX_W'(i)};
      end
    end
  endfunction

  logic [ADDR_SIZE-1:0]       mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_DEPTH_BITS:0]   count_q;
  logic [DROP_CNT_SIZE-1:0]   drop_cnt_q;
  state_t                     state_q, state_d;
  logic [ADDR_SIZE-1:0]       agg_q, agg_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       valid_q, valid_d;
  logic [ADDR_SIZE-1:0]       addr_q, addr_d;

  logic                       full_s, push_s, pop_s, drop_s;
  logic [ADDR_SIZE-1:0]       head_s;
  logic [IDX_W:0]             head_srch_s, next_srch_s;
  logic [ADDR_SIZE:0]         head_vsum_s, next_vsum_s;

  assign full_s      = (count_q == FULL_CNT);
  assign push_s      = nrr_cmd && !full_s;
  assign drop_s      = nrr_cmd && full_s;
  assign head_s      = mem_q[rd_ptr_q];
  assign head_srch_s = find_legal(head_s, 0);
  assign next_srch_s = find_legal(agg_q, int'(idx_q) + 1);
  assign head_vsum_s = victim_sum(head_s, 2'(head_srch_s[IDX_W-1:0]));
  assign next_vsum_s = victim_sum(agg_q, 2'(next_srch_s[IDX_W-1:0]));

  // Next-state and next-victim selection.
  always_comb begin
    state_d = state_q;
    agg_d   = agg_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    pop_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop_s   = 1'b1;
          state_d = ISSUE;
          agg_d   = head_s;
          idx_d   = head_srch_s[IDX_W-1:0];
          valid_d = 1'b1;
          addr_d  = head_vsum_s[ADDR_SIZE-1:0];
        end else begin
          valid_d = 1'b0;
        end
      end
      ISSUE: begin
        if (vrr_ready) begin
          if (next_srch_s[IDX_W]) begin
            idx_d  = next_srch_s[IDX_W-1:0];
            addr_d = next_vsum_s[ADDR_SIZE-1:0];
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            addr_d  = '0;
          end
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        addr_d  = '0;
      end
    endcase
  end

  // FIFO storage; contents are don't-care until a push, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= nrr_addr;
    end
  end

  // FIFO pointers, occupancy and the saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + FIFO_DEPTH_BITS'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + FIFO_DEPTH_BITS'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + (FIFO_DEPTH_BITS+1)'(1);
        2'b01:   count_q <= count_q - (FIFO_DEPTH_BITS+1)'(1);
        default: count_q <= count_q;
      endcase
      if (drop_s && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + DROP_CNT_SIZE'(1);
      end
    end
  end

  // Issue FSM state and the registered victim output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      agg_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      agg_q   <= agg_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign vrr_valid = valid_q;
  assign vrr_addr  = addr_q;
  assign busy      = (count_q != '0) || (state_q != IDLE);
  assign fifo_full = full_s;
  assign drop_cnt  = drop_cnt_q;

endmodule
